// File: rtl/data_ram_pkg.sv
// Shared types and constants for the wait-stated data RAM.
// Holds the FSM encoding, default geometry and the latched-request layout.
package data_ram_pkg;

  localparam int DEPTH_LOG_DEF   = 5;
  localparam int WAIT_CYCLES_DEF = 2;
  localparam int BYTE_W          = 8;
  localparam int WORD_W          = 32;
  localparam int LANES           = WORD_W / BYTE_W;
  localparam int CNT_W           = 4;

  localparam logic [WORD_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic              re;
    logic              we;
    logic [LANES-1:0]  sel;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] dat;
  } req_t;

endpackage

// File: rtl/byte_lane_ram.sv
// One 8-bit lane of the data RAM: synchronous write with enable, asynchronous read.
// Reads return the pre-write contents on the edge a write lands.
module byte_lane_ram
  import data_ram_pkg::*;
#(
  parameter int DEPTH_LOG = DEPTH_LOG_DEF
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [DEPTH_LOG-1:0] addr,
  input  logic [BYTE_W-1:0]    wdat,
  output logic [BYTE_W-1:0]    rdat
);

  logic [BYTE_W-1:0] mem [2**DEPTH_LOG];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdat;
    end
  end

  assign rdat = mem[addr];

endmodule

// File: rtl/data_ram_ws.sv
// Word RAM with WAIT_CYCLES wait states; ack pulses WAIT_CYCLES+2 cycles after a request, stall holds the CPU until then.
// DATA_RAM_ERR_EN flags accesses with address bits above the array instead of wrapping them.
module data_ram_ws
  import data_ram_pkg::*;
#(
  parameter int DEPTH_LOG   = DEPTH_LOG_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re,
  input  logic              we,
  input  logic [WORD_W-1:0] addr,
  input  logic [LANES-1:0]  sel,
  input  logic [WORD_W-1:0] storeData,
  output logic [WORD_W-1:0] loadData,
  output logic              ack,
  output logic              stall,
  output logic              err
);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  req_t                 req_q;
  logic                 accept, access, addr_err;
  logic [DEPTH_LOG-1:0] widx;
  logic [WORD_W-1:0]    rword;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    access  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (re | we) begin
          accept  = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          access  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The request is latched so it completes even if the CPU drops re/we.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      req_q    <= '0;
      loadData <= ZERO_WORD;
    end else begin
      if (accept) begin
        req_q <= '{re: re, we: we, sel: sel, addr: addr, dat: storeData};
        cnt_q <= CNT_W'(WAIT_CYCLES);
      end else if (state_q == ST_WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (access) begin
        if (addr_err) begin
          loadData <= ZERO_WORD;
        end else if (req_q.re) begin
          loadData <= rword;
        end
      end
    end
  end

  assign widx  = req_q.addr[DEPTH_LOG+1:2];
  assign ack   = (state_q == ST_DONE);
  assign stall = (re | we) & ~ack;

`ifdef DATA_RAM_ERR_EN
  logic err_q;
  logic unused_addr;

  assign addr_err    = |req_q.addr[WORD_W-1:DEPTH_LOG+2];
  assign unused_addr = ^req_q.addr[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (access) begin
      err_q <= addr_err;
    end
  end

  assign err = ack & err_q;
`else
  logic unused_addr;

  assign addr_err    = 1'b0;
  assign unused_addr = ^{req_q.addr[WORD_W-1:DEPTH_LOG+2], req_q.addr[1:0]};
  assign err         = 1'b0;
`endif

  // A reset landing on the access edge must not commit the write.
  for (genvar n = 0; n < LANES; n++) begin : g_lane
    byte_lane_ram #(.DEPTH_LOG(DEPTH_LOG)) u_lane (
      .clk  (clk),
      .we   (access & req_q.we & req_q.sel[n] & ~addr_err & ~rst),
      .addr (widx),
      .wdat (req_q.dat[n*BYTE_W +: BYTE_W]),
      .rdat (rword[n*BYTE_W +: BYTE_W])
    );
  end

endmodule

// File: tb/tb_data_ram_ws.sv
// Bench for data_ram_ws: directed scenarios plus random traffic against a word-array model.
// A second instance with no wait states covers back-to-back read pacing.
module tb_data_ram_ws;

  localparam int W = 2;

`ifdef DATA_RAM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        re, we;
  logic [31:0] addr, storeData, loadData;
  logic [3:0]  sel;
  logic        ack, stall, err;

  logic        re0, we0;
  logic [31:0] addr0, sd0, ld0;
  logic [3:0]  sel0;
  logic        ack0, stall0, err0;

  always #5 clk = ~clk;

  data_ram_ws #(.DEPTH_LOG(5), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .re(re), .we(we), .addr(addr), .sel(sel),
    .storeData(storeData), .loadData(loadData), .ack(ack), .stall(stall), .err(err)
  );

  data_ram_ws #(.DEPTH_LOG(5), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .re(re0), .we(we0), .addr(addr0), .sel(sel0),
    .storeData(sd0), .loadData(ld0), .ack(ack0), .stall(stall0), .err(err0)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem_m [32];
  logic [31:0] ld_m;
  logic [31:0] ld_obs;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  function automatic bit bad_addr(input logic [31:0] a);
    return ERR_EN && (a[31:7] != 25'd0);
  endfunction

  // One full request on the W-wait-state instance, checked against the model.
  task automatic xact(input string tag, input bit r, input bit w,
                      input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    int          n;
    int          idx;
    bit          stall_ok;
    bit          e;
    logic [31:0] old;
    re = r; we = w; addr = a; sel = s; storeData = d;
    #1;
    stall_ok = (stall === 1'b1);
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (ack === 1'b1) break;
      if (stall !== 1'b1) stall_ok = 1'b0;
    end
    check_val({tag, "_lat"}, n, W + 2);
    check_val({tag, "_stall"}, {stall_ok, stall}, 32'd2);

    idx = int'(a[6:2]);
    e   = bad_addr(a);
    old = mem_m[idx];
    if (e) ld_m = 32'd0;
    else if (r) ld_m = old;
    if (w && !e) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) mem_m[idx][8*b +: 8] = d[8*b +: 8];
      end
    end
    check_val({tag, "_ld"}, loadData, ld_m);
    check_val({tag, "_err"}, err, e);
    ld_obs = loadData;
    re = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int          n;
    bit          seen;
    bit          exp_ack;
    logic [31:0] prior;
    logic [31:0] a;
    int          op;

    rst = 1'b1; re = 1'b0; we = 1'b0; addr = '0; sel = '0; storeData = '0;
    re0 = 1'b0; we0 = 1'b0; addr0 = '0; sel0 = '0; sd0 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    ld_m = 32'd0;
    check_val("rst_ack", ack, 0);
    check_val("rst_ld", loadData, 0);
    check_val("rst_err", err, 0);
    check_val("rst_stall", stall, 0);

    for (int i = 0; i < 32; i++) xact("init", 1'b0, 1'b1, i * 4, 4'hF, $urandom);

    xact("w030", 1'b0, 1'b1, 32'h08, 4'hF, 32'hDEADBEEF);
    xact("r030", 1'b1, 1'b0, 32'h08, 4'h0, 32'h0);
    check_val("r030_word", ld_obs, 32'hDEADBEEF);

    xact("w031", 1'b0, 1'b1, 32'h08, 4'h1, 32'h00000011);
    xact("r031", 1'b1, 1'b0, 32'h08, 4'h0, 32'h0);
    check_val("r031_word", ld_obs, 32'hDEADBE11);

    xact("rw032", 1'b1, 1'b1, 32'h08, 4'hF, 32'h12345678);
    check_val("rw032_old", ld_obs, 32'hDEADBE11);
    xact("r032", 1'b1, 1'b0, 32'h08, 4'h0, 32'h0);
    check_val("r032_new", ld_obs, 32'h12345678);

    // Reset lands two cycles into the wait window of a write.
    prior = mem_m[3];
    we = 1'b1; addr = 32'h0C; sel = 4'hF; storeData = 32'hFFFFFFFF;
    seen = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (ack === 1'b1) seen = 1'b1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    if (ack === 1'b1) seen = 1'b1;
    rst = 1'b0; we = 1'b0;
    #1;
    ld_m = 32'd0;
    check_val("rst033_noack", seen, 0);
    check_val("rst033_ld", loadData, 0);
    check_val("rst033_err", err, 0);
    xact("r033", 1'b1, 1'b0, 32'h0C, 4'h0, 32'h0);
    check_val("r033_prior", ld_obs, prior);

    xact("w035", 1'b0, 1'b1, 32'h100, 4'hF, 32'hCAFEF00D);
    xact("r035", 1'b1, 1'b0, 32'h0, 4'h0, 32'h0);

    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 2);
      a  = ($urandom_range(0, 5) == 0) ? $urandom : ($urandom & 32'h7F);
      xact("rand", op != 1, op != 0, a, 4'($urandom), $urandom);
    end

    // No-wait-state instance: write then back-to-back reads.
    we0 = 1'b1; addr0 = 32'h10; sel0 = 4'hF; sd0 = 32'hA5A50F0F;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (ack0 === 1'b1) break;
    end
    check_val("w0_lat", n, 2);
    we0 = 1'b0;
    @(posedge clk); #1;
    re0 = 1'b1;
    #1;
    check_val("b2b_stall0", stall0, 1);
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      exp_ack = (k % 3 == 2);
      check_val("b2b_ack", ack0, exp_ack);
      check_val("b2b_stall", stall0, !exp_ack);
      if (exp_ack) check_val("b2b_ld", ld0, 32'hA5A50F0F);
    end
    re0 = 1'b0;
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_ram_ws.md
DATA_RAM_WS -- requirements
Module: data_ram_ws

Interface
REQ-001 SHALL have parameter DEPTH_LOG, default 5: log2 of the word count (32 words).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2: extra wait states per access (0..15).
REQ-003 SHALL have ports, clock and reset first:
  - clk  input  1: single clock, all state on rising edge.
  - rst  input  1: synchronous, active-high reset.
REQ-004 SHALL have port re  input  1: read request, held by CPU until ack.
REQ-005 SHALL have port we  input  1: write request, held by CPU until ack.
REQ-006 SHALL have port addr  input  32: byte address, word index = addr[DEPTH_LOG+1:2].
REQ-007 SHALL have port sel  input  4: byte-lane enables, bit n = storeData[8n+7:8n].
REQ-008 SHALL have port storeData  input  32: write data.
REQ-009 SHALL have port loadData  output  32: registered read data, valid while ack=1.
REQ-010 SHALL have port ack  output  1: one-cycle completion pulse.
REQ-011 SHALL have port stall  output  1: combinational, (re|we) & ~ack.
REQ-012 SHALL have port err  output  1: access-error flag, valid with ack (see Configuration).

Function
REQ-013 SHALL implement FSM IDLE -> WAIT -> DONE -> IDLE.
REQ-014 SHALL, in IDLE with re|we=1, latch addr, sel, storeData, re, we; load counter with WAIT_CYCLES; go to WAIT.
REQ-015 SHALL, in WAIT, decrement the counter each cycle while nonzero.
REQ-016 SHALL, in WAIT with counter 0, perform the access on that edge and go to DONE.
REQ-017 SHALL assert ack only in DONE, then return to IDLE unconditionally; minimum gap between accepts is 1 IDLE cycle.
REQ-018 SHALL give latency = WAIT_CYCLES+2 cycles from request presentation to ack; WAIT_CYCLES=0 gives 2.
REQ-019 SHALL update only the byte lanes with sel bit set on a write; sel=0 writes nothing but still acks.
REQ-020 SHALL capture the addressed word into loadData on a read; loadData SHALL hold its value otherwise and read 0 after reset.
REQ-021 SHALL treat re&we as a write, with loadData returning the pre-write word (read-before-write).
REQ-022 SHALL complete a latched request even if re/we drop during WAIT; the ack still pulses.
REQ-023 SHALL ignore address bits above DEPTH_LOG+1 (wrap) unless DATA_RAM_ERR_EN is defined.

Reset
REQ-024 SHALL, on rst=1 at any state, go to IDLE with counter=0, ack=0, loadData=0, err=0 and discard any pending write.
REQ-025 SHALL NOT reset memory contents.

Configuration
REQ-026 SHALL, with DATA_RAM_ERR_EN defined and a nonzero addr[31:DEPTH_LOG+2], suppress the write, return loadData=0 and assert err with ack.
REQ-027 SHALL, with DATA_RAM_ERR_EN undefined, tie err to 0 and wrap addresses.

Structure
REQ-028 SHALL take the FSM state encoding, default parameter values, ZERO_WORD and byte/word widths from shared package data_ram_pkg.
REQ-029 SHALL instantiate sub-module byte_lane_ram (8-bit x 2^DEPTH_LOG, sync write, enable) four times, one per lane.

Verification
REQ-030 SHALL cover: W=2, write 0xDEADBEEF to 0x08 with sel=1111, then read 0x08 -> ack 4 cycles after each request, loadData=0xDEADBEEF.
REQ-031 SHALL cover: after REQ-030, write 0x00000011 to 0x08 with sel=0001, then read -> 0xDEADBE11.
REQ-032 SHALL cover: re=we=1 to 0x08 with data 0x12345678 -> loadData=0xDEADBE11; a following read returns 0x12345678.
REQ-033 SHALL cover: rst pulsed during WAIT of a write of 0xFFFFFFFF to 0x0C -> no ack, state IDLE, a following read of 0x0C returns the prior value.
REQ-034 SHALL cover: W=0, back-to-back reads -> ack every 3 cycles, stall high except in the ack cycles.
REQ-035 SHALL cover: write to 0x100 with DATA_RAM_ERR_EN -> err=1 with ack and word 0 unchanged; without the macro -> word 0 is written.
